// File: rtl/comp_branch_seq.sv
// Multi-cycle branch/set comparator: compares two operands SLICE bits per cycle, MSB slice first,
// and reports equality, less-than and the mode-selected branch condition behind a start/busy/done handshake.
module comp_branch_seq #(
  parameter int unsigned MSB   = 31,
  parameter int unsigned SLICE = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2:0]     modo,
  input  logic [MSB:0]   rdd1,
  input  logic [MSB:0]   rdd2,
  output logic           busy,
  output logic           done,
  output logic           f_iguales,
  output logic           f_menor,
  output logic           f_resultado
);

  localparam int unsigned W   = MSB + 1;
  localparam int unsigned NSL = W / SLICE;
  localparam int unsigned CW  = (NSL > 1) ? $clog2(NSL) : 1;

  localparam logic [2:0] M_EQ  = 3'b000;
  localparam logic [2:0] M_NE  = 3'b001;
  localparam logic [2:0] M_LTZ = 3'b010;
  localparam logic [2:0] M_GEZ = 3'b011;
  localparam logic [2:0] M_LEZ = 3'b100;
  localparam logic [2:0] M_GTZ = 3'b101;
  localparam logic [2:0] M_LT  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t         state, state_n;
  logic [MSB:0]   a_q, a_n, b_q, b_n;
  logic [2:0]     modo_q, modo_n;
  logic           eq_acc, eq_acc_n, lt_acc, lt_acc_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           busy_n, done_n, ig_n, me_n, res_n;

  logic [MSB:0]   a_prep, b_prep;
  logic [SLICE-1:0] a_sl, b_sl;
  logic           sl_diff, eq_upd, lt_upd, res_upd, zero_b, sgn;

  // Operand preparation: zero-compare modes substitute b=0; signed modes flip the sign bits
  // so the slice engine only ever needs an unsigned compare.
  always_comb begin
    zero_b = (modo >= M_LTZ) && (modo <= M_GTZ);
    sgn    = (modo >= M_LTZ) && (modo <= M_LT);
    a_prep = rdd1;
    b_prep = zero_b ? '0 : rdd2;
    if (sgn) begin
      a_prep[MSB] = ~a_prep[MSB];
      b_prep[MSB] = ~b_prep[MSB];
    end
  end

  // Current slice verdict; the first differing slice decides lt, later slices are ignored.
  always_comb begin
    a_sl    = a_q[MSB -: SLICE];
    b_sl    = b_q[MSB -: SLICE];
    sl_diff = (a_sl != b_sl);
    eq_upd  = eq_acc & ~sl_diff;
    lt_upd  = (eq_acc & sl_diff) ? (a_sl < b_sl) : lt_acc;
    case (modo_q)
      M_EQ:    res_upd = eq_upd;
      M_NE:    res_upd = ~eq_upd;
      M_GEZ:   res_upd = ~lt_upd;
      M_LEZ:   res_upd = lt_upd | eq_upd;
      M_GTZ:   res_upd = ~lt_upd & ~eq_upd;
      default: res_upd = lt_upd;
    endcase
  end

  always_comb begin
    state_n  = state;
    a_n      = a_q;
    b_n      = b_q;
    modo_n   = modo_q;
    eq_acc_n = eq_acc;
    lt_acc_n = lt_acc;
    cnt_n    = cnt;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    ig_n     = f_iguales;
    me_n     = f_menor;
    res_n    = f_resultado;
    case (state)
      S_BUSY: begin
        busy_n   = 1'b1;
        eq_acc_n = eq_upd;
        lt_acc_n = lt_upd;
        a_n      = a_q << SLICE;
        b_n      = b_q << SLICE;
        cnt_n    = cnt + CW'(1);
        if (cnt == CW'(NSL - 1)) begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          cnt_n   = '0;
          ig_n    = eq_upd;
          me_n    = lt_upd;
          res_n   = res_upd;
        end
      end
      default: begin
        if (state == S_DONE) state_n = S_IDLE;
        if (start) begin
          state_n  = S_BUSY;
          busy_n   = 1'b1;
          a_n      = a_prep;
          b_n      = b_prep;
          modo_n   = modo;
          eq_acc_n = 1'b1;
          lt_acc_n = 1'b0;
          cnt_n    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      modo_q      <= '0;
      eq_acc      <= 1'b0;
      lt_acc      <= 1'b0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      f_iguales   <= 1'b0;
      f_menor     <= 1'b0;
      f_resultado <= 1'b0;
    end else begin
      state       <= state_n;
      a_q         <= a_n;
      b_q         <= b_n;
      modo_q      <= modo_n;
      eq_acc      <= eq_acc_n;
      lt_acc      <= lt_acc_n;
      cnt         <= cnt_n;
      busy        <= busy_n;
      done        <= done_n;
      f_iguales   <= ig_n;
      f_menor     <= me_n;
      f_resultado <= res_n;
    end
  end

endmodule
